iobus_uart_tx: RTL and testbench
================================

// Module: iobus_uart_tx
// PURPOSE
// - Memory-mapped UART transmitter that responds to the OTTER MCU IOBUS (MCU is initiator, this block is responder).
// - MCU stores a byte to the DATA register; the byte is queued in a FIFO and serialised 8N1 on TX.
// - MCU loads from the STATUS register to poll space and busy state. It sits beside the other IOBUS peripherals in the top-level wrapper.
// PARAMETERS
// - BASE_ADDR     32'h1100_0100  DATA register address; STATUS register is at BASE_ADDR+4.
// - CLKS_PER_BIT  434            CLK cycles per UART bit (50 MHz / 115200). Legal range is >= 2.
// - FIFO_DEPTH    8              Queue entries. Must be a power of 2, >= 2.
// PORTS
// - CLK         in   1   system clock; all state changes on the rising edge
// - RST         in   1   synchronous, active-high reset
// - IOBUS_ADDR  in   32  MCU IO address
// - IOBUS_OUT   in   32  MCU store data; only [7:0] is used for DATA
// - IOBUS_WR    in   1   MCU IO write strobe, one cycle per store
// - IOBUS_IN    out  32  read data to MCU, combinational from IOBUS_ADDR
// - TX          out  1   serial line, idles high
// - IRQ         out  1   FIFO-empty interrupt; present only with UART_TX_IRQ_EN
// BEHAVIOUR
// - Reset: TX=1, FIFO empty (count 0), FSM in IDLE, overflow flag 0, IRQ=0. This applies at any time, including mid-frame: TX returns to 1 at the next edge and the partial frame is abandoned.
// - Write DATA (IOBUS_WR & IOBUS_ADDR==BASE_ADDR):
//   - If the FIFO is not full, IOBUS_OUT[7:0] is pushed this edge.
//   - If full, the byte is dropped and sticky OVF is set.
//   - Fullness is evaluated before any same-cycle pop, so a write while full is dropped even if the FSM pops that cycle.
// - Write STATUS (addr BASE_ADDR+4): IOBUS_OUT[3]=1 clears OVF. All other bits are ignored.
// - Read, IOBUS_IN, combinational:
//   - addr BASE_ADDR+4: {16'b0, count[7:0], 4'b0, OVF, EMPTY, FULL, BUSY}, with BUSY in bit 0.
//   - addr BASE_ADDR: 0.
//   - any other address: 32'h0.
// - BUSY = (state!=IDLE) | !EMPTY.
// - FIFO: wr_ptr/rd_ptr have log2(FIFO_DEPTH)+1 bits and wrap modulo 2*DEPTH. FULL is defined as MSBs differing with low bits equal; EMPTY as the pointers being equal.
// - FSM states IDLE, START, DATA, STOP. Each uses a baud counter running 0..CLKS_PER_BIT-1 and a bit index running 0..7.
//   - IDLE: TX=1. If !EMPTY, pop into shift register and go to START. The pop edge is the same edge at which TX drives 0.
//   - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
//   - DATA: TX=shift[0], LSB first, each bit CLKS_PER_BIT cycles. After bit 7, go to STOP.
//   - STOP: TX=1 for CLKS_PER_BIT cycles. Then, if !EMPTY, pop and go directly to START (no idle gap); otherwise go to IDLE.
// - Frame length is exactly 10*CLKS_PER_BIT cycles.
// - Latency: a write to an empty idle block makes TX fall on the 2nd rising edge after the write edge (push edge, then pop edge).
// - A write that arrives while the FSM is mid-frame never disturbs the shift register.
// CONFIGURATION
// - UART_TX_IRQ_EN defined:
//   - IRQ port exists.
//   - IRQ is a registered one-cycle pulse on the edge where the FSM enters IDLE from STOP with the FIFO empty.
//   - IRQ is 0 in reset.
// - UART_TX_IRQ_EN undefined: no IRQ port and no IRQ logic. All other behaviour is identical.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
// - Single byte: write 8'hA5 to BASE. TX shows 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each held 4 cycles. Total is 40 cycles, and TX falls 2 edges after the write.
// - Back-to-back: write 8'h00 then 8'hFF. The second start bit follows the first stop bit with no idle cycle. BUSY reads 1 until the final stop completes, then 0.
// - Overflow: 5 writes in 5 consecutive cycles. The 1st is popped at the 2nd edge, so writes 2-5 fill the FIFO and none are lost.
//   - A 6th write while count==4 is dropped, and STATUS[3]=1.
//   - Write 32'h8 to BASE+4; STATUS[3] reads 0.
// - Status decode: reset, then read BASE+4 -> 32'h0000_0004 (EMPTY). Read an unmapped address -> 32'h0.
// - Reset mid-frame: assert RST during DATA bit 3 for one cycle. TX=1 at the next edge, STATUS reads 32'h4, and no further frame is sent.
// - UART_TX_IRQ_EN: after a single byte, IRQ pulses exactly once, for 1 cycle, at the STOP->IDLE edge. There is no pulse between back-to-back frames.

Source files
------------

// File: rtl/iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// iobus_uart_tx
//
// Memory-mapped UART transmitter on the OTTER MCU IOBUS (the MCU is the
// initiator and this block responds). The MCU stores a byte to the DATA
// register, where it is queued in a small FIFO and sent 8N1 on TX. The MCU
// polls the STATUS register for free space, overflow and busy state.
//
// Register map:
//   BASE_ADDR     DATA   write: push IOBUS_OUT[7:0]     read: 0
//   BASE_ADDR+4   STATUS write: IOBUS_OUT[3]=1 clears OVF
//                        read : {16'b0, count[7:0], 4'b0, OVF, EMPTY, FULL, BUSY}
//
// Parameters:
//   BASE_ADDR     DATA register address (STATUS lives at BASE_ADDR+4)
//   CLKS_PER_BIT  clock cycles per UART bit, >= 2
//   FIFO_DEPTH    queue entries, a power of two, >= 2
//
// Ports:
//   CLK         in   1   system clock, rising edge
//   RST         in   1   synchronous active-high reset
//   IOBUS_ADDR  in   32  MCU IO address
//   IOBUS_OUT   in   32  MCU store data
//   IOBUS_WR    in   1   MCU IO write strobe, one cycle per store
//   IOBUS_IN    out  32  read data to the MCU, combinational from IOBUS_ADDR
//   TX          out  1   serial line, idles high
//   IRQ         out  1   FIFO-empty pulse (only when UART_TX_IRQ_EN is defined)
//
// Build option: define UART_TX_IRQ_EN to add the IRQ port. IRQ is a
// registered one-cycle pulse on the edge where the transmitter returns to
// idle after a stop bit with nothing left to send.
// -----------------------------------------------------------------------------
module iobus_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        TX
`ifdef UART_TX_IRQ_EN
  ,
  output logic        IRQ
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       STAT_ADDR = BASE_ADDR + 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and pointers. The extra pointer MSB distinguishes a full
  // queue from an empty one when the low index bits match.
  logic [7:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  logic [PTR_W:0] fifo_count;
  logic [7:0]     count8;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;

  // Transmitter state
  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_n;
  logic [7:0]        shift_reg;
  logic [7:0]        shift_n;
  logic              baud_done;
  logic              tx_n;

  // Bus decode
  logic data_sel;
  logic stat_sel;
  logic wr_data;
  logic wr_stat;
  logic ovf;
  logic busy;

  // Upper store-data bits have no meaning for either register.
  logic unused_bits;
  assign unused_bits = ^IOBUS_OUT[31:8];

  assign data_sel = (IOBUS_ADDR == BASE_ADDR);
  assign stat_sel = (IOBUS_ADDR == STAT_ADDR);
  assign wr_data  = IOBUS_WR & data_sel;
  assign wr_stat  = IOBUS_WR & stat_sel;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;
  assign count8     = 8'(fifo_count);

  // Fullness is taken before any pop in the same cycle, so a store to a full
  // queue is dropped even when the transmitter frees a slot on that edge.
  assign push = wr_data & ~full;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // A byte leaves the queue either from idle or at the end of a stop bit,
  // which lets consecutive frames run with no idle gap between them.
  assign pop = ~empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_done));

  assign busy = (state != ST_IDLE) | ~empty;

  // FIFO write side. Storage has no reset; only the pointers define content.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= IOBUS_OUT[7:0];
    end
  end

  // FIFO pointers wrap naturally modulo twice the depth.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow: set by a dropped store, cleared by writing bit 3 of
  // STATUS. The two writes target different addresses so they never collide.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf <= 1'b0;
    end else if (wr_data & full) begin
      ovf <= 1'b1;
    end else if (wr_stat & IOBUS_OUT[3]) begin
      ovf <= 1'b0;
    end
  end

  // Next-state logic for the serialiser. The shift register is only loaded
  // on a pop, so stores arriving mid-frame never touch the byte being sent.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    shift_n = shift_reg;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          state_n = ST_START;
          baud_n  = '0;
          shift_n = fifo_mem[rd_ptr[PTR_W-1:0]];
        end
      end
      ST_START: begin
        if (baud_done) begin
          state_n = ST_DATA;
          baud_n  = '0;
          bit_n   = 3'd0;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_n  = '0;
          shift_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = ST_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (!empty) begin
            state_n = ST_START;
            shift_n = fifo_mem[rd_ptr[PTR_W-1:0]];
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = '0;
      end
    endcase
  end

  // TX is registered from the next state so the line changes on the same
  // edge as the state does, with no combinational glitches on the pin.
  always_comb begin
    tx_n = 1'b1;
    if (state_n == ST_START) begin
      tx_n = 1'b0;
    end else if (state_n == ST_DATA) begin
      tx_n = shift_n[0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      TX        <= 1'b1;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_idx   <= bit_n;
      shift_reg <= shift_n;
      TX        <= tx_n;
    end
  end

`ifdef UART_TX_IRQ_EN
  // Pulse on the edge that takes the FSM from STOP back to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= (state == ST_STOP) & baud_done & empty;
    end
  end
`endif

  // Combinational read mux; DATA and unmapped addresses read as zero.
  always_comb begin
    IOBUS_IN = 32'h0;
    if (stat_sel) begin
      IOBUS_IN = {16'b0, count8, 4'b0, ovf, empty, full, busy};
    end
  end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_iobus_uart_tx
//
// Self-checking bench for iobus_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Bytes expected on the line are queued when the store is issued; a TX
// monitor pops them as start bits appear and checks every cycle of the
// frame against the ideal 8N1 waveform.
// -----------------------------------------------------------------------------
module tb_iobus_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] STAT  = 32'h1100_0104;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'h0;
  logic [31:0] IOBUS_OUT = 32'h0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        TX;
`ifdef UART_TX_IRQ_EN
  logic        IRQ;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Scoreboard and monitor state
  logic [7:0] exp_q[$];
  int         start_cycles[$];
  bit         in_frame = 1'b0;
  bit         frame_ok;
  bit         spurious;
  int         sample_idx;
  logic [7:0] cur_byte;
  logic [9:0] cur_frame;
  logic [9:0] obs_frame;
  int         irq_count = 0;
  int         irq_cyc = 0;

  iobus_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .IOBUS_IN  (IOBUS_IN),
    .TX        (TX)
`ifdef UART_TX_IRQ_EN
    ,
    .IRQ       (IRQ)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // TX monitor: samples the line on every falling edge, pops the next
  // expected byte at a start bit and compares all 10*CPB samples.
  always @(negedge CLK) begin
`ifdef UART_TX_IRQ_EN
    if (IRQ === 1'b1) begin
      irq_count++;
      irq_cyc = cyc;
    end
`endif
    if (RST) begin
      in_frame = 1'b0;
      exp_q.delete();
    end else if (in_frame) begin
      if (TX !== cur_frame[sample_idx / CPB]) frame_ok = 1'b0;
      if ((sample_idx % CPB) == CPB / 2) obs_frame[sample_idx / CPB] = TX;
      sample_idx++;
      if (sample_idx == 10 * CPB) begin
        in_frame = 1'b0;
        if (!spurious) begin
          tests_run++;
          if (!frame_ok) begin
            tests_failed++;
            $display("[TB] FAIL frame_%02h: line bits %b expected %b", cur_byte, obs_frame, cur_frame);
          end
        end
      end
    end else if (TX === 1'b0) begin
      start_cycles.push_back(cyc);
      in_frame   = 1'b1;
      frame_ok   = 1'b1;
      spurious   = 1'b0;
      sample_idx = 1;
      obs_frame  = 10'h0;
      if (exp_q.size() == 0) begin
        spurious = 1'b1;
        cur_byte = 8'h00;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_frame: got start bit at cycle %0d expected idle line", cyc);
      end else begin
        cur_byte = exp_q.pop_front();
      end
      cur_frame = {1'b1, cur_byte, 1'b0};
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle IO store; the write takes effect at the next rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    @(posedge CLK);
    #1;
    IOBUS_WR   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    IOBUS_ADDR = addr;
    #1;
    data = IOBUS_IN;
  endtask

  // Counts cycles until STATUS.BUSY drops.
  task automatic measure_busy(output int cycles);
    logic [31:0] v;
    cycles = 0;
    while (cycles < 500) begin
      bus_read(STAT, v);
      if (v[0] !== 1'b1) break;
      @(posedge CLK);
      #1;
      cycles++;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && (exp_q.size() != 0 || in_frame)) begin
      @(posedge CLK);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0 || in_frame) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d bytes pending expected 0 within %0d cycles", name, exp_q.size(), budget);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    tests_run++;
    if (TX !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_tx: got %b expected 1", TX);
    end
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected 00000004", v);
    end
`ifdef UART_TX_IRQ_EN
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_irq: got %b expected 0", IRQ);
    end
`endif
  endtask

  task automatic test_status_decode();
    logic [31:0] v;
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin
      tests_failed++;
      $display("[TB] FAIL decode_status: got %h expected 00000004", v);
    end
    bus_read(BASE, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL decode_data: got %h expected 00000000", v);
    end
    bus_read(32'h1100_0200, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL decode_unmapped: got %h expected 00000000", v);
    end
    bus_read(BASE + 32'd8, v);
    tests_run++;
    if (v !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL decode_base_plus_8: got %h expected 00000000", v);
    end
  endtask

  task automatic test_single_byte();
    int          busy_cycles;
    int          irq_before;
    logic [31:0] v;
    sync();
    irq_before = irq_count;
    start_cycles.delete();
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_00A5);
    tests_run++;
    if (TX !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_tx_push_edge: got %b expected 1", TX);
    end
    @(posedge CLK);
    #1;
    tests_run++;
    if (TX !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_tx_pop_edge: got %b expected 0", TX);
    end
    measure_busy(busy_cycles);
    tests_run++;
    if (busy_cycles != 10 * CPB) begin
      tests_failed++;
      $display("[TB] FAIL single_frame_length: got %0d expected %0d", busy_cycles, 10 * CPB);
    end
    wait_drain("single_drain", 100);
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin
      tests_failed++;
      $display("[TB] FAIL single_status_after: got %h expected 00000004", v);
    end
`ifdef UART_TX_IRQ_EN
    tests_run++;
    if (irq_count - irq_before != 1) begin
      tests_failed++;
      $display("[TB] FAIL single_irq_pulses: got %0d expected 1", irq_count - irq_before);
    end
    tests_run++;
    if (start_cycles.size() == 0 || irq_cyc - start_cycles[0] != 10 * CPB) begin
      tests_failed++;
      $display("[TB] FAIL single_irq_timing: got %0d expected %0d", irq_cyc - (start_cycles.size() == 0 ? 0 : start_cycles[0]), 10 * CPB);
    end
`else
    irq_before = irq_count;
`endif
  endtask

  task automatic test_back_to_back();
    int          busy_cycles;
    int          gap;
    int          irq_before;
    sync();
    irq_before = irq_count;
    start_cycles.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    bus_write(BASE, 32'h0000_0000);
    bus_write(BASE, 32'h0000_00FF);
    measure_busy(busy_cycles);
    tests_run++;
    if (busy_cycles != 20 * CPB) begin
      tests_failed++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d expected %0d", busy_cycles, 20 * CPB);
    end
    wait_drain("b2b_drain", 100);
    gap = (start_cycles.size() >= 2) ? start_cycles[1] - start_cycles[0] : -1;
    tests_run++;
    if (gap != 10 * CPB) begin
      tests_failed++;
      $display("[TB] FAIL b2b_start_spacing: got %0d expected %0d", gap, 10 * CPB);
    end
`ifdef UART_TX_IRQ_EN
    tests_run++;
    if (irq_count - irq_before != 1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_irq_pulses: got %0d expected 1", irq_count - irq_before);
    end
`else
    irq_before = irq_count;
`endif
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    sync();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h11 + 8'(i));
      bus_write(BASE, 32'h11 + i);
    end
    bus_write(BASE, 32'h0000_0066);
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_040B) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status_set: got %h expected 0000040b", v);
    end
    bus_write(STAT, 32'h0000_0008);
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0403) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status_cleared: got %h expected 00000403", v);
    end
    wait_drain("ovf_drain", 400);
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status_after: got %h expected 00000004", v);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int          low_samples;
    sync();
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_00A5);
    repeat (18) @(posedge CLK);
    #1;
    tests_run++;
    if (TX !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_bit3: got %b expected 0", TX);
    end
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tests_run++;
    if (TX !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_tx: got %b expected 1", TX);
    end
    bus_read(STAT, v);
    tests_run++;
    if (v !== 32'h0000_0004) begin
      tests_failed++;
      $display("[TB] FAIL midreset_status: got %h expected 00000004", v);
    end
    low_samples = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      #1;
      if (TX !== 1'b1) low_samples++;
    end
    tests_run++;
    if (low_samples != 0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_line_idle: got %0d low cycles expected 0", low_samples);
    end
  endtask

  initial begin
    test_reset();
    test_status_decode();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop in case a task is stuck somewhere unexpected.
  initial begin
    #500000;
    tests_failed++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
